// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: clocked exhaustive truth-table tester for a small combinational cell.
// Steps test_data through every input combination. Each vector is held for SETTLE cycles
// plus one sample cycle. The sampled results are scored against the TRUTH table.
// Optional build macro: GTS_STOP_ON_FAIL_EN makes the run end at the first mismatching vector.
module gate_test_sequencer #(
   parameter int unsigned           N_IN   = 2,
   parameter int unsigned           SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]  TRUTH  = 4'b0111
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            results,
   output logic [N_IN-1:0] test_data,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   fail_count,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam int unsigned     CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t          state;
   logic [N_IN-1:0] vec;
   logic [CW-1:0]   cnt;
   logic            mismatch;
   logic [N_IN:0]   fail_next;
   logic            finish;

   // Score the current sample and decide whether this CHECK ends the run
   always_comb begin
      mismatch  = (results !== TRUTH[vec]);
      fail_next = fail_count + {{N_IN{1'b0}}, mismatch};
`ifdef GTS_STOP_ON_FAIL_EN
      finish    = (vec == VEC_LAST) || mismatch;
`else
      finish    = (vec == VEC_LAST);
`endif
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         vec            <= '0;
         cnt            <= '0;
         test_data      <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_count     <= '0;
         first_fail_vec <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  vec            <= '0;
                  cnt            <= '0;
                  fail_count     <= '0;
                  first_fail_vec <= '0;
                  test_data      <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  state          <= DRIVE;
               end
            end
            DRIVE: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               fail_count <= fail_next;
               if (mismatch && (fail_count == '0)) begin
                  first_fail_vec <= vec;
               end
               if (finish) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  test_data <= '0;
                  pass      <= (fail_next == '0);
               end else begin
                  vec       <= vec + 1'b1;
                  test_data <= vec + 1'b1;
                  cnt       <= '0;
                  state     <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Synthesizable, single-clock controller for exhaustive functional test of a small combinational cell in the Digital library, for example nand2.
- Steps `test_data` through every input combination.
- Waits a programmable settle time per vector, then samples the cell's `results`.
- Compares each sample against a parameterised truth table and reports pass/fail, a failure count and the first failing vector.
- Replaces hand-written per-gate delay-based drivers with one clocked sequencer reused across cells.

## Interface
- `N_IN`, default 2: number of cell inputs; width of `test_data`; 1..6.
- `SETTLE`, default 2: cycles each vector is driven before the sample cycle; must be ≥1.
- `TRUTH`, default 4'b0111: expected output, bit i = expected `results` for `test_data`=i. Width 2^N_IN. The default is nand2.
- `clk` in 1: the single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a test run; sampled in IDLE and DONE only.
- `results` in 1: cell output under test.
- `test_data` out N_IN: stimulus to the cell inputs.
- `busy` out 1: run in progress (DRIVE or CHECK).
- `done` out 1: high while in DONE.
- `pass` out 1: valid while `done`; 1 iff `fail_count`==0.
- `fail_count` out N_IN+1: number of mismatching vectors in the current/last run.
- `first_fail_vec` out N_IN: index of the first mismatch; meaningful only when `fail_count`≠0.

## Operation
- **States:** IDLE, DRIVE, CHECK, DONE.
- **Reset values:** state IDLE; all outputs 0.
- **IDLE:**
  - `test_data`=0, `busy`=0, `done`=0.
  - If `start`=1: vec←0, settle counter←0, `fail_count`←0, `first_fail_vec`←0, then go to DRIVE.
- **DRIVE:**
  - `test_data`=vec, `busy`=1.
  - Settle counter increments each cycle. When it equals SETTLE-1, go to CHECK.
- **CHECK** (one cycle):
  - `test_data`=vec.
  - At the closing edge, compare `results` with TRUTH[vec]. Any inequality, including X/Z in simulation, is a mismatch; implement with case inequality.
  - On mismatch: `fail_count`+1. If `fail_count` was 0, `first_fail_vec`←vec.
  - If vec = 2^N_IN−1, go to DONE. Otherwise vec+1, counter←0, go to DRIVE.
- **DONE:**
  - `done`=1, `busy`=0, `test_data`=0, `pass`=(`fail_count`==0).
  - Results hold until `start` or `rst`.
  - `start`=1 behaves as in IDLE: counters are cleared and the run restarts.
- **Start handling:** `start` in DRIVE/CHECK is ignored; there is no queuing or abort.
- **Counter width:** `fail_count` cannot overflow, since its maximum is 2^N_IN in N_IN+1 bits. vec does not wrap; the terminal vector always exits to DONE.
- **Reset mid-run:** `rst` at any edge returns to IDLE with all outputs 0 at that edge. A partial run is discarded.

## Timing
- Each vector is held for SETTLE+1 cycles. `results` is sampled at the end of the last of those cycles.
- Take the edge sampling `start` as edge 0:
  - `test_data`=0 and `busy`=1 from edge 0.
  - Vector i is applied from edge i·(SETTLE+1).
  - Vector i is sampled at edge (i+1)·(SETTLE+1).
- `done` rises at edge 2^N_IN·(SETTLE+1); `busy` falls at the same edge.
  - Defaults: `test_data` changes at edges 0, 3, 6, 9; `done` at edge 12.
- `fail_count`/`first_fail_vec` update at the CHECK closing edge and are visible the next cycle.
- `rst` wins over `start` in the same cycle.

## Configuration
- **`GTS_STOP_ON_FAIL_EN` defined:** CHECK with a mismatch goes directly to DONE.
  - `fail_count` ends at 1 and `first_fail_vec` is the failing index.
  - `done` rises at the closing edge of that CHECK.
- **Undefined (default):** every vector is always run, regardless of mismatches.

## Test plan
- **Ideal nand2 model, defaults:**
  - Stimulus: `start` pulse.
  - Response: `test_data` 00/01/10/11 at edges 0/3/6/9; `done`=1 at edge 12; `pass`=1; `fail_count`=0.
- **`results` stuck at 1:**
  - Response: `fail_count`=1, `first_fail_vec`=3, `pass`=0, `done` at edge 12.
- **`results` stuck at 0, macro undefined:**
  - Response: `fail_count`=3, `first_fail_vec`=0, `done` at edge 12.
- **`results` stuck at 0, macro defined:**
  - Response: `done` at edge 3, `fail_count`=1, `first_fail_vec`=0, `test_data`=0.
- **`start` re-pulsed at edge 5, then `rst` at edge 7:**
  - Response: the edge-5 start is ignored. After edge 7: IDLE, `test_data`=0, `busy`=0, `done`=0, `fail_count`=0.
- **`results`=X during vector 1 with an otherwise ideal model, then `start` again while `done`:**
  - First run: `fail_count`=1, `first_fail_vec`=1.
  - Restart: counters cleared at the `start` edge; the second run with an ideal model ends with `pass`=1.
